// File: rtl/reg_status_file_mp_pkg.sv
// Shared types and sizes for the multi-port register/rename-status file
// and its branch checkpoint ring.
package reg_status_file_mp_pkg;

  localparam int XLEN         = 32;
  localparam int NREG         = 32;
  localparam int RIDX_W       = 5;
  localparam int ROB_AW       = 4;
  localparam int CKPT_N       = 4;
  localparam int CKPT_W       = $clog2(CKPT_N);
  localparam int DEF_ISSUE_W  = 2;
  localparam int DEF_COMMIT_W = 2;

  typedef struct packed {
    logic              busy;
    logic [ROB_AW-1:0] tag;
  } status_t;

  typedef status_t [NREG-1:0] status_map_t;

  // Ring pointer: the extra wrap bit tells a full ring from an empty one.
  typedef struct packed {
    logic              wrap;
    logic [CKPT_W-1:0] idx;
  } ckpt_ptr_t;

  function automatic logic [CKPT_W:0] ptr_diff(input ckpt_ptr_t a, input ckpt_ptr_t b);
    logic [CKPT_W:0] av;
    logic [CKPT_W:0] bv;
    av = a;
    bv = b;
    return av - bv;
  endfunction

  function automatic ckpt_ptr_t ptr_add(input ckpt_ptr_t a, input logic [CKPT_W:0] n);
    logic [CKPT_W:0] av;
    av = a;
    return ckpt_ptr_t'(av + n);
  endfunction

endpackage

// File: rtl/reg_status_file_mp_ckpt_ring.sv
// Ring of busy/tag snapshots taken at branches; supports in-order release,
// selective rollback to one entry and full flush.
module reg_status_file_mp_ckpt_ring
  import reg_status_file_mp_pkg::*;
#(
  parameter int COMMIT_W = DEF_COMMIT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       take,
  input  status_map_t                snap_in,
  input  logic                       br_valid,
  input  logic [CKPT_W-1:0]          br_ckpt,
  input  logic                       br_mispred,
  input  logic [COMMIT_W-1:0]        cmt_valid,
  input  logic [COMMIT_W*RIDX_W-1:0] cmt_rd,
  input  logic [COMMIT_W*ROB_AW-1:0] cmt_tag,
  output logic [CKPT_W-1:0]          ckpt_id,
  output logic                       full,
  output status_map_t                restore_map
);

  localparam logic [CKPT_W:0] PTR_ONE  = (CKPT_W+1)'(1);
  localparam logic [CKPT_W:0] PTR_FULL = (CKPT_W+1)'(CKPT_N);

  ckpt_ptr_t         head, head_n, tail, tail_n, br_ptr;
  logic [CKPT_N-1:0] valid, valid_n;
  logic [CKPT_W:0]   span, kill_span, adv;
  logic              adv_stop;
  logic              mispredict, resolve_ok, take_ok;
  status_map_t       snap     [CKPT_N];
  status_map_t       snap_clr [CKPT_N];
  logic [RIDX_W-1:0] c_rd     [COMMIT_W];
  logic [ROB_AW-1:0] c_tag    [COMMIT_W];

  for (genvar c = 0; c < COMMIT_W; c++) begin : g_unpack
    assign c_rd[c]  = cmt_rd[c*RIDX_W +: RIDX_W];
    assign c_tag[c] = cmt_tag[c*ROB_AW +: ROB_AW];
  end

  assign mispredict = br_valid & br_mispred & ~flush;
  assign resolve_ok = br_valid & ~br_mispred & ~flush;
  assign take_ok    = take & ~flush & ~mispredict;
  assign full       = (ptr_diff(tail, head) == PTR_FULL);
  assign ckpt_id    = tail.idx;
  assign br_ptr     = ptr_add(head, {1'b0, br_ckpt - head.idx});
  assign kill_span  = ptr_diff(tail, br_ptr);

  // A retiring producer is no longer pending in any snapshot that still names it.
  always_comb begin
    for (int e = 0; e < CKPT_N; e++) begin
      snap_clr[e] = snap[e];
      for (int c = 0; c < COMMIT_W; c++) begin
        if (cmt_valid[c] && c_rd[c] != '0 && snap[e][c_rd[c]].busy &&
            snap[e][c_rd[c]].tag == c_tag[c])
          snap_clr[e][c_rd[c]] = '0;
      end
    end
  end

  assign restore_map = snap_clr[br_ckpt];

  always_comb begin
    valid_n = valid;
    tail_n  = tail;
    if (flush) begin
      valid_n = '0;
    end else if (mispredict) begin
      tail_n = ptr_add(br_ptr, PTR_ONE);
      for (int i = 0; i < CKPT_N; i++) begin
        if ((CKPT_W+1)'(i) < kill_span) valid_n[br_ptr.idx + CKPT_W'(i)] = 1'b0;
      end
    end else begin
      if (resolve_ok) valid_n[br_ckpt] = 1'b0;
      if (take_ok) begin
        valid_n[tail.idx] = 1'b1;
        tail_n            = ptr_add(tail, PTR_ONE);
      end
    end
  end

  // Release resolved entries in order; stop at the oldest still-live branch.
  always_comb begin
    span     = ptr_diff(tail_n, head);
    adv      = '0;
    adv_stop = 1'b0;
    for (int i = 0; i < CKPT_N; i++) begin
      if (!adv_stop && (CKPT_W+1)'(i) < span && !valid_n[head.idx + CKPT_W'(i)])
        adv = adv + PTR_ONE;
      else
        adv_stop = 1'b1;
    end
    head_n = flush ? tail : ptr_add(head, adv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
    end else if (rdy) begin
      head  <= head_n;
      tail  <= tail_n;
      valid <= valid_n;
    end
  end

  // NOTE: snapshot storage has no reset; an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int e = 0; e < CKPT_N; e++) snap[e] <= snap_clr[e];
      if (take_ok) snap[tail.idx] <= snap_in;
    end
  end

  a_no_take_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    (rdy && take_ok) |-> !full);
  a_resolve_live_entry: assert property (@(posedge clk) disable iff (!rst_n)
    (rdy && br_valid && !flush) |-> valid[br_ckpt]);

endmodule

// File: rtl/reg_status_file_mp.sv
// Architectural register file with per-register rename status, same-cycle
// rename/commit bypass on the read ports and checkpointed branch recovery.
module reg_status_file_mp
  import reg_status_file_mp_pkg::*;
#(
  parameter int ISSUE_W  = DEF_ISSUE_W,
  parameter int COMMIT_W = DEF_COMMIT_W
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic [2*ISSUE_W*RIDX_W-1:0]   rs_idx_in,
  output logic [2*ISSUE_W*XLEN-1:0]     rs_val_out,
  output logic [2*ISSUE_W-1:0]          rs_busy_out,
  output logic [2*ISSUE_W*ROB_AW-1:0]   rs_tag_out,
  input  logic [ISSUE_W-1:0]            disp_valid_in,
  input  logic [ISSUE_W*RIDX_W-1:0]     disp_rd_in,
  input  logic [ISSUE_W*ROB_AW-1:0]     disp_tag_in,
  input  logic [ISSUE_W-1:0]            disp_ckpt_in,
  output logic [CKPT_W-1:0]             ckpt_id_out,
  output logic                          ckpt_full_out,
  input  logic [COMMIT_W-1:0]           cmt_valid_in,
  input  logic [COMMIT_W*RIDX_W-1:0]    cmt_rd_in,
  input  logic [COMMIT_W*XLEN-1:0]      cmt_val_in,
  input  logic [COMMIT_W*ROB_AW-1:0]    cmt_tag_in,
  input  logic                          br_valid_in,
  input  logic [CKPT_W-1:0]             br_ckpt_in,
  input  logic                          br_mispred_in,
  input  logic                          flush_in
);

  localparam int NRD = 2*ISSUE_W;

  logic [XLEN-1:0]   data [NREG];
  status_map_t       map, map_clr, map_disp, snap_map, restore_map;
  logic              mispredict, ckpt_req;

  logic [RIDX_W-1:0] c_rd   [COMMIT_W];
  logic [XLEN-1:0]   c_val  [COMMIT_W];
  logic [ROB_AW-1:0] c_tag  [COMMIT_W];
  logic [RIDX_W-1:0] d_rd   [ISSUE_W];
  logic [ROB_AW-1:0] d_tag  [ISSUE_W];
  logic [RIDX_W-1:0] r_idx  [NRD];
  logic [XLEN-1:0]   rd_val [NRD];
  status_t           rd_st  [NRD];

  for (genvar c = 0; c < COMMIT_W; c++) begin : g_cmt
    assign c_rd[c]  = cmt_rd_in[c*RIDX_W +: RIDX_W];
    assign c_val[c] = cmt_val_in[c*XLEN +: XLEN];
    assign c_tag[c] = cmt_tag_in[c*ROB_AW +: ROB_AW];
  end

  for (genvar s = 0; s < ISSUE_W; s++) begin : g_disp
    assign d_rd[s]  = disp_rd_in[s*RIDX_W +: RIDX_W];
    assign d_tag[s] = disp_tag_in[s*ROB_AW +: ROB_AW];
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign r_idx[p]                       = rs_idx_in[p*RIDX_W +: RIDX_W];
    assign rs_val_out[p*XLEN +: XLEN]     = rd_val[p];
    assign rs_busy_out[p]                 = rd_st[p].busy;
    assign rs_tag_out[p*ROB_AW +: ROB_AW] = rd_st[p].tag;
  end

  assign mispredict = br_valid_in & br_mispred_in & ~flush_in;

  // Operand read: stored state, overridden by a retiring producer, then by an
  // older slot renaming the same register, then by the x0 rule.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_val[p] = data[r_idx[p]];
      rd_st[p]  = map[r_idx[p]];
      for (int c = 0; c < COMMIT_W; c++) begin
        if (cmt_valid_in[c] && c_rd[c] == r_idx[p] && map[r_idx[p]].busy &&
            map[r_idx[p]].tag == c_tag[c]) begin
          rd_val[p] = c_val[c];
          rd_st[p]  = '0;
        end
      end
      for (int k = 0; k < ISSUE_W; k++) begin
        if (k < p/2 && disp_valid_in[k] && d_rd[k] == r_idx[p])
          rd_st[p] = '{busy: 1'b1, tag: d_tag[k]};
      end
      if (r_idx[p] == '0) begin
        rd_val[p] = '0;
        rd_st[p]  = '0;
      end
    end
  end

  // NOTE: every variable in a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    map_clr = map;
    for (int c = 0; c < COMMIT_W; c++) begin
      if (cmt_valid_in[c] && c_rd[c] != '0 && map[c_rd[c]].busy &&
          map[c_rd[c]].tag == c_tag[c])
        map_clr[c_rd[c]] = '0;
    end
  end

  // NOTE: blocking assignments here let each slot build on the older slots' renames.
  always_comb begin
    map_disp = map_clr;
    snap_map = map_clr;
    ckpt_req = 1'b0;
    for (int s = 0; s < ISSUE_W; s++) begin
      if (disp_valid_in[s] && d_rd[s] != '0)
        map_disp[d_rd[s]] = '{busy: 1'b1, tag: d_tag[s]};
      if (disp_valid_in[s] && disp_ckpt_in[s] && !ckpt_req) begin
        snap_map = map_disp;
        ckpt_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      map <= '0;
    end else if (rdy_in) begin
      if (flush_in)        map <= '0;
      else if (mispredict) map <= restore_map;
      else                 map <= map_disp;
    end
  end

  // Committed values land regardless of flush/mispredict; the youngest port wins.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int r = 0; r < NREG; r++) data[r] <= '0;
    end else if (rdy_in) begin
      for (int c = 0; c < COMMIT_W; c++) begin
        if (cmt_valid_in[c] && c_rd[c] != '0) data[c_rd[c]] <= c_val[c];
      end
    end
  end

  reg_status_file_mp_ckpt_ring #(.COMMIT_W(COMMIT_W)) u_ring (
    .clk         (clk_in),
    .rst_n       (rst_n_in),
    .rdy         (rdy_in),
    .flush       (flush_in),
    .take        (ckpt_req),
    .snap_in     (snap_map),
    .br_valid    (br_valid_in),
    .br_ckpt     (br_ckpt_in),
    .br_mispred  (br_mispred_in),
    .cmt_valid   (cmt_valid_in),
    .cmt_rd      (cmt_rd_in),
    .cmt_tag     (cmt_tag_in),
    .ckpt_id     (ckpt_id_out),
    .full        (ckpt_full_out),
    .restore_map (restore_map)
  );

  a_one_ckpt_per_cycle: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    rdy_in |-> $onehot0(disp_valid_in & disp_ckpt_in));

endmodule

// File: tb/tb_reg_status_file_mp.sv
// Directed bench for reg_status_file_mp: reads, bypasses, commits,
// checkpoint rollback, ring occupancy, flush and stall.
module tb_reg_status_file_mp;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic         rdy_in;
  logic [19:0]  rs_idx_in;
  logic [127:0] rs_val_out;
  logic [3:0]   rs_busy_out;
  logic [15:0]  rs_tag_out;
  logic [1:0]   disp_valid_in;
  logic [9:0]   disp_rd_in;
  logic [7:0]   disp_tag_in;
  logic [1:0]   disp_ckpt_in;
  logic [1:0]   ckpt_id_out;
  logic         ckpt_full_out;
  logic [1:0]   cmt_valid_in;
  logic [9:0]   cmt_rd_in;
  logic [63:0]  cmt_val_in;
  logic [7:0]   cmt_tag_in;
  logic         br_valid_in;
  logic [1:0]   br_ckpt_in;
  logic         br_mispred_in;
  logic         flush_in;

  int n_checks;
  int n_fail;

  reg_status_file_mp dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .rs_idx_in     (rs_idx_in),
    .rs_val_out    (rs_val_out),
    .rs_busy_out   (rs_busy_out),
    .rs_tag_out    (rs_tag_out),
    .disp_valid_in (disp_valid_in),
    .disp_rd_in    (disp_rd_in),
    .disp_tag_in   (disp_tag_in),
    .disp_ckpt_in  (disp_ckpt_in),
    .ckpt_id_out   (ckpt_id_out),
    .ckpt_full_out (ckpt_full_out),
    .cmt_valid_in  (cmt_valid_in),
    .cmt_rd_in     (cmt_rd_in),
    .cmt_val_in    (cmt_val_in),
    .cmt_tag_in    (cmt_tag_in),
    .br_valid_in   (br_valid_in),
    .br_ckpt_in    (br_ckpt_in),
    .br_mispred_in (br_mispred_in),
    .flush_in      (flush_in)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] val_of(int p);
    return rs_val_out[p*32 +: 32];
  endfunction

  function automatic logic [3:0] tag_of(int p);
    return rs_tag_out[p*4 +: 4];
  endfunction

  task automatic idle();
    rdy_in = 1'b1; rs_idx_in = '0;
    disp_valid_in = '0; disp_rd_in = '0; disp_tag_in = '0; disp_ckpt_in = '0;
    cmt_valid_in = '0; cmt_rd_in = '0; cmt_val_in = '0; cmt_tag_in = '0;
    br_valid_in = 1'b0; br_ckpt_in = '0; br_mispred_in = 1'b0; flush_in = 1'b0;
  endtask

  task automatic set_rs(int p, logic [4:0] idx);
    rs_idx_in[p*5 +: 5] = idx;
  endtask

  task automatic set_disp(int s, logic [4:0] rd, logic [3:0] tag, logic ckpt);
    disp_valid_in[s] = 1'b1; disp_rd_in[s*5 +: 5] = rd;
    disp_tag_in[s*4 +: 4] = tag; disp_ckpt_in[s] = ckpt;
  endtask

  task automatic set_cmt(int c, logic [4:0] rd, logic [31:0] val, logic [3:0] tag);
    cmt_valid_in[c] = 1'b1; cmt_rd_in[c*5 +: 5] = rd;
    cmt_val_in[c*32 +: 32] = val; cmt_tag_in[c*4 +: 4] = tag;
  endtask

  task automatic set_br(logic [1:0] id, logic mis);
    br_valid_in = 1'b1; br_ckpt_in = id; br_mispred_in = mis;
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset();
    idle(); rst_n_in = 1'b1; #2; rst_n_in = 1'b0;
    set_rs(0, 5'd5); #1;
    n_checks++; if (val_of(0) !== 32'h0) begin n_fail++; $display("FAIL reset_val: got %0h want 0", val_of(0)); end
    n_checks++; if (rs_busy_out[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", rs_busy_out[0]); end
    n_checks++; if (tag_of(0) !== 4'h0) begin n_fail++; $display("FAIL reset_tag: got %0h want 0", tag_of(0)); end
    n_checks++; if (ckpt_full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", ckpt_full_out); end
    n_checks++; if (ckpt_id_out !== 2'd0) begin n_fail++; $display("FAIL reset_ckpt_id: got %0d want 0", ckpt_id_out); end
    @(negedge clk_in); rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_dispatch();
    idle(); set_disp(0, 5'd5, 4'd3, 1'b0); set_disp(1, 5'd0, 4'd6, 1'b0); set_rs(2, 5'd0); #1;
    n_checks++; if (rs_busy_out[2] !== 1'b0 || tag_of(2) !== 4'h0) begin
      n_fail++; $display("FAIL x0_rename_bypass: got busy %0b tag %0h want 0 0", rs_busy_out[2], tag_of(2)); end
    tick();
    idle(); set_rs(0, 5'd5); set_rs(1, 5'd0); #1;
    n_checks++; if (rs_busy_out[0] !== 1'b1) begin n_fail++; $display("FAIL disp_busy: got %0b want 1", rs_busy_out[0]); end
    n_checks++; if (tag_of(0) !== 4'd3) begin n_fail++; $display("FAIL disp_tag: got %0h want 3", tag_of(0)); end
    n_checks++; if (rs_busy_out[1] !== 1'b0) begin n_fail++; $display("FAIL x0_never_busy: got %0b want 0", rs_busy_out[1]); end
    tick();
  endtask

  task automatic test_same_cycle();
    idle(); set_disp(0, 5'd7, 4'd2, 1'b0);
    set_rs(0, 5'd7); set_rs(2, 5'd7); set_rs(3, 5'd5); #1;
    n_checks++; if (rs_busy_out[2] !== 1'b1 || tag_of(2) !== 4'd2) begin
      n_fail++; $display("FAIL older_slot_bypass: got busy %0b tag %0h want 1 2", rs_busy_out[2], tag_of(2)); end
    n_checks++; if (rs_busy_out[0] !== 1'b0 || tag_of(0) !== 4'd0) begin
      n_fail++; $display("FAIL own_slot_no_bypass: got busy %0b tag %0h want 0 0", rs_busy_out[0], tag_of(0)); end
    n_checks++; if (rs_busy_out[3] !== 1'b1 || tag_of(3) !== 4'd3) begin
      n_fail++; $display("FAIL stored_status: got busy %0b tag %0h want 1 3", rs_busy_out[3], tag_of(3)); end
    tick();
  endtask

  task automatic test_commit_bypass();
    idle(); set_cmt(0, 5'd7, 32'hDEAD, 4'd2); set_rs(0, 5'd7); #1;
    n_checks++; if (rs_busy_out[0] !== 1'b0 || val_of(0) !== 32'hDEAD || tag_of(0) !== 4'd0) begin
      n_fail++; $display("FAIL commit_fwd: got busy %0b val %0h tag %0h want 0 dead 0", rs_busy_out[0], val_of(0), tag_of(0)); end
    tick();
    idle(); set_rs(0, 5'd7); #1;
    n_checks++; if (rs_busy_out[0] !== 1'b0 || val_of(0) !== 32'hDEAD) begin
      n_fail++; $display("FAIL commit_stored: got busy %0b val %0h want 0 dead", rs_busy_out[0], val_of(0)); end
    set_cmt(0, 5'd9, 32'h1, 4'd7); set_cmt(1, 5'd9, 32'h2, 4'd8);
    tick();
    idle(); set_rs(1, 5'd9); #1;
    n_checks++; if (val_of(1) !== 32'h2) begin n_fail++; $display("FAIL youngest_commit: got %0h want 2", val_of(1)); end
    set_disp(0, 5'd7, 4'd9, 1'b0);
    tick();
    idle(); set_cmt(0, 5'd7, 32'h55, 4'd9); set_disp(0, 5'd7, 4'd10, 1'b0); set_rs(0, 5'd7); #1;
    n_checks++; if (rs_busy_out[0] !== 1'b0 || val_of(0) !== 32'h55) begin
      n_fail++; $display("FAIL commit_fwd_redisp: got busy %0b val %0h want 0 55", rs_busy_out[0], val_of(0)); end
    tick();
    idle(); set_rs(0, 5'd7); #1;
    n_checks++; if (rs_busy_out[0] !== 1'b1 || tag_of(0) !== 4'd10 || val_of(0) !== 32'h55) begin
      n_fail++; $display("FAIL redisp_wins: got busy %0b tag %0h val %0h want 1 a 55", rs_busy_out[0], tag_of(0), val_of(0)); end
    tick();
  endtask

  task automatic test_ckpt_mispredict();
    idle(); set_disp(0, 5'd1, 4'd4, 1'b1); set_disp(1, 5'd2, 4'd6, 1'b0); #1;
    n_checks++; if (ckpt_id_out !== 2'd0) begin n_fail++; $display("FAIL ckpt_id_first: got %0d want 0", ckpt_id_out); end
    tick();
    idle(); set_disp(0, 5'd1, 4'd5, 1'b0); #1;
    n_checks++; if (ckpt_id_out !== 2'd1) begin n_fail++; $display("FAIL ckpt_id_adv: got %0d want 1", ckpt_id_out); end
    tick();
    idle(); set_rs(0, 5'd1); #1;
    n_checks++; if (rs_busy_out[0] !== 1'b1 || tag_of(0) !== 4'd5) begin
      n_fail++; $display("FAIL rename_again: got busy %0b tag %0h want 1 5", rs_busy_out[0], tag_of(0)); end
    set_br(2'd0, 1'b1); set_disp(0, 5'd3, 4'd11, 1'b0);
    tick();
    idle(); set_rs(0, 5'd1); set_rs(1, 5'd2); set_rs(2, 5'd3); set_rs(3, 5'd5); #1;
    n_checks++; if (rs_busy_out[0] !== 1'b1 || tag_of(0) !== 4'd4) begin
      n_fail++; $display("FAIL restore_x1: got busy %0b tag %0h want 1 4", rs_busy_out[0], tag_of(0)); end
    n_checks++; if (rs_busy_out[1] !== 1'b0) begin n_fail++; $display("FAIL restore_younger_slot: got %0b want 0", rs_busy_out[1]); end
    n_checks++; if (rs_busy_out[2] !== 1'b0) begin n_fail++; $display("FAIL mispred_disp_ignored: got %0b want 0", rs_busy_out[2]); end
    n_checks++; if (rs_busy_out[3] !== 1'b1 || tag_of(3) !== 4'd3) begin
      n_fail++; $display("FAIL restore_x5: got busy %0b tag %0h want 1 3", rs_busy_out[3], tag_of(3)); end
    n_checks++; if (ckpt_id_out !== 2'd1 || ckpt_full_out !== 1'b0) begin
      n_fail++; $display("FAIL restore_tail: got id %0d full %0b want 1 0", ckpt_id_out, ckpt_full_out); end
    set_disp(1, 5'd0, 4'd12, 1'b1);
    tick();
    idle(); set_disp(0, 5'd1, 4'd13, 1'b0);
    tick();
    idle(); set_br(2'd1, 1'b1); set_cmt(0, 5'd1, 32'h44, 4'd4);
    tick();
    idle(); set_rs(0, 5'd1); #1;
    n_checks++; if (rs_busy_out[0] !== 1'b0 || val_of(0) !== 32'h44 || tag_of(0) !== 4'd0) begin
      n_fail++; $display("FAIL restore_with_commit: got busy %0b val %0h tag %0h want 0 44 0", rs_busy_out[0], val_of(0), tag_of(0)); end
    n_checks++; if (ckpt_id_out !== 2'd2) begin n_fail++; $display("FAIL restore2_tail: got %0d want 2", ckpt_id_out); end
    tick();
  endtask

  task automatic test_ckpt_full();
    idle(); rst_n_in = 1'b0; #1; rst_n_in = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(); set_disp(0, 5'(10 + i), 4'(1 + i), 1'b1); #1;
      n_checks++; if (ckpt_id_out !== 2'(i) || ckpt_full_out !== 1'b0) begin
        n_fail++; $display("FAIL fill_%0d: got id %0d full %0b want %0d 0", i, ckpt_id_out, ckpt_full_out, i); end
      tick();
    end
    idle(); #1;
    n_checks++; if (ckpt_full_out !== 1'b1) begin n_fail++; $display("FAIL ring_full: got %0b want 1", ckpt_full_out); end
    set_br(2'd1, 1'b0);
    tick();
    idle(); #1;
    n_checks++; if (ckpt_full_out !== 1'b1) begin n_fail++; $display("FAIL out_of_order_resolve: got %0b want 1", ckpt_full_out); end
    set_br(2'd0, 1'b0);
    tick();
    idle(); #1;
    n_checks++; if (ckpt_full_out !== 1'b0) begin n_fail++; $display("FAIL head_jump: got %0b want 0", ckpt_full_out); end
    set_disp(0, 5'd14, 4'd5, 1'b1); #1;
    n_checks++; if (ckpt_id_out !== 2'd0) begin n_fail++; $display("FAIL wrap_id: got %0d want 0", ckpt_id_out); end
    tick();
    idle(); #1;
    n_checks++; if (ckpt_full_out !== 1'b0) begin n_fail++; $display("FAIL count3_full: got %0b want 0", ckpt_full_out); end
    set_disp(0, 5'd15, 4'd6, 1'b1);
    tick();
    idle(); #1;
    n_checks++; if (ckpt_full_out !== 1'b1 || ckpt_id_out !== 2'd2) begin
      n_fail++; $display("FAIL count4: got full %0b id %0d want 1 2", ckpt_full_out, ckpt_id_out); end
    tick();
  endtask

  task automatic test_flush();
    idle(); flush_in = 1'b1; set_cmt(0, 5'd3, 32'd9, 4'd0); set_disp(0, 5'd16, 4'd7, 1'b0);
    tick();
    idle(); set_rs(0, 5'd3); set_rs(1, 5'd10); set_rs(2, 5'd15); set_rs(3, 5'd16); #1;
    n_checks++; if (val_of(0) !== 32'd9 || rs_busy_out[0] !== 1'b0) begin
      n_fail++; $display("FAIL flush_commit: got val %0h busy %0b want 9 0", val_of(0), rs_busy_out[0]); end
    n_checks++; if (rs_busy_out[3:1] !== 3'b000) begin n_fail++; $display("FAIL flush_busy: got %0b want 000", rs_busy_out[3:1]); end
    n_checks++; if (ckpt_full_out !== 1'b0 || ckpt_id_out !== 2'd2) begin
      n_fail++; $display("FAIL flush_ring: got full %0b id %0d want 0 2", ckpt_full_out, ckpt_id_out); end
    tick();
  endtask

  task automatic test_hold();
    idle(); rdy_in = 1'b0; set_disp(0, 5'd4, 4'd5, 1'b1); set_cmt(0, 5'd3, 32'h77, 4'd0);
    repeat (3) tick();
    n_checks++; if (ckpt_id_out !== 2'd2) begin n_fail++; $display("FAIL hold_ring: got %0d want 2", ckpt_id_out); end
    idle(); set_rs(0, 5'd3); set_rs(1, 5'd4); #1;
    n_checks++; if (val_of(0) !== 32'd9) begin n_fail++; $display("FAIL hold_data: got %0h want 9", val_of(0)); end
    n_checks++; if (rs_busy_out[1] !== 1'b0) begin n_fail++; $display("FAIL hold_status: got %0b want 0", rs_busy_out[1]); end
    n_checks++; if (ckpt_full_out !== 1'b0) begin n_fail++; $display("FAIL hold_full: got %0b want 0", ckpt_full_out); end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_dispatch();
    test_same_cycle();
    test_commit_bypass();
    test_ckpt_mispredict();
    test_ckpt_full();
    test_flush();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
